// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier, divider).
package arith_pkg;
    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor through a ripple of full_subtractor cells.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);
    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r_next,
    output logic             o_q_bit
);
    // The restored remainder is always below the divisor, so its top bit is
    // zero and only the low WIDTH bits take part in the shift.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH+1:0] w_borrow;

    assign w_shift     = {i_r, i_q_msb};
    assign w_sub       = {1'b0, i_d};
    assign w_borrow[0] = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
        full_subtractor u_fs (
            .i_a    (w_shift[i]),
            .i_b    (w_sub[i]),
            .i_bin  (w_borrow[i]),
            .o_diff (w_diff[i]),
            .o_bout (w_borrow[i+1])
        );
    end

    // Sign bit and borrow-out agree here; either marks a negative trial.
    assign o_q_bit  = ~(w_diff[WIDTH] | w_borrow[WIDTH+1]);
    assign o_r_next = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake
// shared with the shift-add multiplier.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);
    // Handshake: start is taken only in IDLE or DONE; done is a one-cycle
    // pulse and the result outputs hold until the next accepted start.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_r_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r      (r_r),
        .i_q_msb  (r_q[WIDTH-1]),
        .i_d      (r_d),
        .o_r_next (w_r_next),
        .o_q_bit  (w_q_bit)
    );

    assign w_q_next  = {r_q[WIDTH-2:0], w_q_bit};
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        quotient  <= w_q_next;
                        remainder <= w_r_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        r_q         <= dividend;
                        r_d         <= divisor;
                        r_r         <= '0;
                        r_cnt       <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            busy    <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain-arithmetic division model.
module tb_seq_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // expected entries are {div_by_zero, quotient, remainder}
    logic [2*W:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ones;
        ones = '1;
        if (b == 0) return {1'b1, ones, a};
        return {1'b0, a / b, a % b};
    endfunction

    // Present one request for a single accepting edge; returns #1 after it.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(ref_div(a, b));
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Edges from the accepting edge until done is seen (-1 on timeout).
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = busy ? 1 : 0;
        if (done) lat = 0;
        else begin
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                #1;
                if (busy) busy_cyc++;
                if (done) begin
                    lat = i;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero, dbg_state} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b st=%0d, expected all 0",
                     busy, done, quotient, remainder, div_by_zero, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [2*W:0] e;
        issue(8'd100, 8'd7);
        n_checks++;
        if (dbg_state !== 2'd1) begin
            n_errors++;
            $display("FAIL basic_state_run: got %0d, expected 1", dbg_state);
        end
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== W || bc !== W) begin
            n_errors++;
            $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d, expected %0d/%0d", lat, bc, W, W);
        end
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== e || e !== {1'b0, 8'd14, 8'd2}) begin
            n_errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, expected q=14 r=2 dbz=0",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL basic_done_pulse: got done=%b st=%0d, expected done=0 st=0", done, dbg_state);
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] as[3] = '{8'd255, 8'd5, 8'd0};
        logic [W-1:0] bs[3] = '{8'd1, 8'd9, 8'd3};
        int lat, bc;
        logic [2*W:0] e;
        for (int k = 0; k < 3; k++) begin
            issue(as[k], bs[k]);
            wait_done(lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if (lat !== W) begin
                n_errors++;
                $display("FAIL pattern_latency %0d/%0d: got %0d, expected %0d", as[k], bs[k], lat, W);
            end
            n_checks++;
            if ({div_by_zero, quotient, remainder} !== e) begin
                n_errors++;
                $display("FAIL pattern_result %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=%b",
                         as[k], bs[k], quotient, remainder, div_by_zero, e[2*W-1:W], e[W-1:0], e[2*W]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic [2*W:0] e;
        issue(8'd37, 8'd0);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if (lat !== 0 || bc !== 0) begin
            n_errors++;
            $display("FAIL dbz_timing: got latency=%0d busy_cycles=%0d, expected 0/0", lat, bc);
        end
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== e) begin
            n_errors++;
            $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b, expected q=255 r=37 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        issue(8'd200, 8'd10);
        n_checks++;
        if (div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL dbz_clear_on_accept: got %b, expected 0", div_by_zero);
        end
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== e || lat !== W) begin
            n_errors++;
            $display("FAIL dbz_followup: got q=%0d r=%0d dbz=%b lat=%0d, expected q=20 r=0 dbz=0 lat=%0d",
                     quotient, remainder, div_by_zero, lat, W);
        end
    endtask

    task automatic test_start_ignored();
        int lat = -1;
        int n_done = 0;
        logic [2*W:0] e;
        logic [2*W:0] got = '0;
        issue(8'd200, 8'd10);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 4; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (lat < 0) begin
                    lat = i;
                    got = {div_by_zero, quotient, remainder};
                end
            end
        end
        e = exp_q.pop_front();
        n_checks++;
        if (n_done !== 1 || lat !== W) begin
            n_errors++;
            $display("FAIL ignored_start_done: got %0d pulses latency=%0d, expected 1 pulse latency=%0d",
                     n_done, lat, W);
        end
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL ignored_start_result: got q=%0d r=%0d, expected q=20 r=0", got[2*W-1:W], got[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [2*W:0] e;
        issue(8'd100, 8'd7);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== e || lat !== W) begin
            n_errors++;
            $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d, expected q=14 r=2 lat=%0d",
                     quotient, remainder, lat, W);
        end
        start = 1'b1; dividend = 8'd50; divisor = 8'd6;
        exp_q.push_back(ref_div(8'd50, 8'd6));
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || quotient !== 8'd14 || remainder !== 8'd2) begin
            n_errors++;
            $display("FAIL b2b_accept: got busy=%b q=%0d r=%0d, expected busy=1 q=14 r=2",
                     busy, quotient, remainder);
        end
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== e || lat !== W || bc !== W) begin
            n_errors++;
            $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d busy=%0d, expected q=8 r=2 lat=%0d busy=%0d",
                     quotient, remainder, lat, bc, W, W);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        int stray = 0;
        logic [2*W:0] e;
        issue(8'd144, 8'd12);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero, dbg_state} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d dbz=%b st=%0d, expected all 0",
                     busy, done, quotient, remainder, div_by_zero, dbg_state);
        end
        void'(exp_q.pop_front());
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b1; dividend = 8'd144; divisor = 8'd12;
        exp_q.push_back(ref_div(8'd144, 8'd12));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        e = exp_q.pop_front();
        n_checks++;
        if (stray !== 0) begin
            n_errors++;
            $display("FAIL reset_no_done: got %0d done pulses under reset, expected 0", stray);
        end
        n_checks++;
        if ({div_by_zero, quotient, remainder} !== e || lat !== W) begin
            n_errors++;
            $display("FAIL reset_rerun: got q=%0d r=%0d lat=%0d, expected q=12 r=0 lat=%0d",
                     quotient, remainder, lat, W);
        end
    endtask

    task automatic test_random();
        int lat, bc;
        logic [2*W:0] e;
        logic [W-1:0] a, b;
        for (int k = 0; k < 30; k++) begin
            a = W'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 4));
                default: b = W'($urandom_range(1, 255));
            endcase
            issue(a, b);
            wait_done(lat, bc);
            e = exp_q.pop_front();
            n_checks++;
            if ({div_by_zero, quotient, remainder} !== e || lat !== ((b == 0) ? 0 : W)) begin
                n_errors++;
                $display("FAIL random %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b",
                         a, b, quotient, remainder, div_by_zero, lat, e[2*W-1:W], e[W-1:0], e[2*W]);
            end
            if (b != 0) begin
                n_checks++;
                if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
                    n_errors++;
                    $display("FAIL random_invariant %0d/%0d: got q=%0d r=%0d", a, b, quotient, remainder);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
